// File: rtl/dice_roller_mux_if.sv
// Pin-side bundle of the dice roller: raw buttons in, display drive and result out.
// state is the FSM state, brought out for observation only.
interface dice_roller_mux_if #(
    parameter int DIGITS = 3
);
    logic [6:0]          btn;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   com;
    logic [4*DIGITS-1:0] value;
    logic                busy;
    logic                done;
    logic [1:0]          state;

    modport master (output btn, input seg, com, value, busy, done, state);
    modport slave  (input btn, output seg, com, value, busy, done, state);
endinterface

// File: rtl/dice_roller_mux.sv
// Multi-digit BCD dice roller with button debounce and a multiplexed 7-segment display.
// Define DICE_SPINDOWN_EN to compile in the decelerating SPIN phase after release.
module dice_roller_mux #(
    parameter int DIGITS     = 3,
    parameter int PRESCALE_W = 10,
    parameter int DEB_TICKS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    dice_roller_mux_if.slave bus
);
    localparam int VW = 4 * DIGITS;
    localparam int SW = $clog2(DIGITS);

`ifdef DICE_SPINDOWN_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROLL = 2'd1, ST_SPIN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROLL = 2'd1} state_t;
`endif

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;

    always_ff @(posedge clk) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = &pre_cnt;

    // The d100 button does not exist on a two-digit build.
    logic [6:0] btn_raw;
    logic [6:0] deb_lvl;
    logic [6:0] deb_prev;
    logic [3:0] deb_cnt [7];

    assign btn_raw = (DIGITS == 2) ? {1'b0, bus.btn[5:0]} : bus.btn;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl  <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 7; i++) deb_cnt[i] <= '0;
        end else begin
            deb_prev <= deb_lvl;
            if (tick) begin
                for (int i = 0; i < 7; i++) begin
                    if (btn_raw[i] == deb_lvl[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == 4'(DEB_TICKS - 1)) begin
                        deb_lvl[i] <= ~deb_lvl[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    logic [6:0] rise;
    logic       press;
    logic [2:0] press_idx;

    assign rise = deb_lvl & ~deb_prev;

    // Scan downwards so the lowest simultaneous edge is the one that sticks.
    always_comb begin
        press     = 1'b0;
        press_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (rise[i]) begin
                press     = 1'b1;
                press_idx = 3'(i);
            end
        end
    end

    function automatic logic [VW-1:0] die_bcd(input logic [2:0] idx);
        case (idx)
            3'd0:    die_bcd = VW'(16'h0004);
            3'd1:    die_bcd = VW'(16'h0006);
            3'd2:    die_bcd = VW'(16'h0008);
            3'd3:    die_bcd = VW'(16'h0010);
            3'd4:    die_bcd = VW'(16'h0012);
            3'd5:    die_bcd = VW'(16'h0020);
            3'd6:    die_bcd = VW'(16'h0100);
            default: die_bcd = VW'(16'h0004);
        endcase
    endfunction

    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] res;
        logic          borrow;
        logic [3:0]    d;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = d - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    state_t        state, state_next;
    logic [VW-1:0] value, value_next;
    logic [VW-1:0] die_max, die_max_next;
    logic [VW-1:0] size_bcd;
    logic [VW-1:0] step_val;
    logic          done_r;

    assign size_bcd = die_bcd(press_idx);
    assign step_val = (value == VW'(1)) ? die_max : bcd_dec(value);

`ifdef DICE_SPINDOWN_EN
    // Step k of the spin-down waits 2**k ticks before its single decrement.
    logic [2:0] step, step_next;
    logic [3:0] ivl, ivl_next;
    logic [4:0] span_last;

    assign span_last = (5'd1 << step) - 5'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            value   <= VW'(1);
            die_max <= VW'(4);
            done_r  <= 1'b0;
`ifdef DICE_SPINDOWN_EN
            step    <= '0;
            ivl     <= '0;
`endif
        end else begin
            state   <= state_next;
            value   <= value_next;
            die_max <= die_max_next;
            done_r  <= (state != ST_IDLE) && (state_next == ST_IDLE);
`ifdef DICE_SPINDOWN_EN
            step    <= step_next;
            ivl     <= ivl_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        value_next   = value;
        die_max_next = die_max;
`ifdef DICE_SPINDOWN_EN
        step_next    = step;
        ivl_next     = ivl;
`endif
        case (state)
            ST_IDLE: begin
                if (press) begin
                    die_max_next = size_bcd;
                    value_next   = size_bcd;
                    state_next   = ST_ROLL;
                end
            end
            ST_ROLL: begin
                // The release cycle holds the value; the roll only runs while held.
                if (deb_lvl == 7'd0) begin
`ifdef DICE_SPINDOWN_EN
                    state_next = ST_SPIN;
                    step_next  = 3'd0;
                    ivl_next   = 4'd0;
`else
                    state_next = ST_IDLE;
`endif
                end else begin
                    value_next = step_val;
                end
            end
`ifdef DICE_SPINDOWN_EN
            ST_SPIN: begin
                if (press) begin
                    die_max_next = size_bcd;
                    value_next   = size_bcd;
                    state_next   = ST_ROLL;
                end else if (tick) begin
                    if ({1'b0, ivl} == span_last) begin
                        value_next = step_val;
                        ivl_next   = 4'd0;
                        if (step == 3'd4) state_next = ST_IDLE;
                        else              step_next  = step + 3'd1;
                    end else begin
                        ivl_next = ivl + 4'd1;
                    end
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    logic [SW-1:0]     scan, msd;
    logic [3:0]        scan_digit;
    logic              show;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] com_r;

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        case (d)
            4'd0:    seg_dec = 7'b0111111;
            4'd1:    seg_dec = 7'b0000110;
            4'd2:    seg_dec = 7'b1011011;
            4'd3:    seg_dec = 7'b1001111;
            4'd4:    seg_dec = 7'b1100110;
            4'd5:    seg_dec = 7'b1101101;
            4'd6:    seg_dec = 7'b1111101;
            4'd7:    seg_dec = 7'b0000111;
            4'd8:    seg_dec = 7'b1111111;
            4'd9:    seg_dec = 7'b1101111;
            default: seg_dec = 7'b0000000;
        endcase
    endfunction

    // Digit 0 is always shown, so msd starts there.
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd0) msd = SW'(i);
        end
    end

    assign scan_digit = value[4*scan +: 4];
    assign show       = (state != ST_ROLL) && (scan <= msd);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan  <= '0;
            seg_r <= '0;
            com_r <= '0;
        end else begin
            scan  <= (scan == SW'(DIGITS - 1)) ? '0 : scan + 1'b1;
            seg_r <= seg_dec(scan_digit);
            com_r <= show ? (DIGITS'(1) << scan) : '0;
        end
    end

    assign bus.seg   = seg_r;
    assign bus.com   = com_r;
    assign bus.value = value;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = done_r;
    assign bus.state = state;
endmodule

// File: tb/tb_dice_roller_mux.sv
// Directed bench for dice_roller_mux: a 3-digit and a 2-digit instance at a fast prescale.
// Define DICE_SPINDOWN_EN for both RTL and bench to exercise the spin-down phase.
module tb_dice_roller_mux;
    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dice_roller_mux_if #(.DIGITS(3)) bus3 ();
    dice_roller_mux_if #(.DIGITS(2)) bus2 ();

    dice_roller_mux #(.DIGITS(3), .PRESCALE_W(2), .DEB_TICKS(2)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave)
    );
    dice_roller_mux #(.DIGITS(2), .PRESCALE_W(2), .DEB_TICKS(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    // cyc = number of rising edges since reset was released
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Ticks land on edges where cyc is a multiple of 4 (PRESCALE_W = 2).
    function automatic int next_tick(input int c);
        return ((c + 3) / 4) * 4;
    endfunction

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'((n / 100) % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic test_reset();
        logic [2:0] exp_com3;
        logic [1:0] exp_com2;
        logic [6:0] exp_seg3;
        rst      = 1'b1;
        bus3.btn = '0;
        bus2.btn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus3.value !== 12'h001 || bus3.busy !== 1'b0 || bus3.done !== 1'b0 ||
            bus3.seg !== 7'd0 || bus3.com !== 3'd0 || bus3.state !== 2'd0) begin
            $display("FAIL reset3 got value=%h busy=%b done=%b seg=%b com=%b state=%0d exp 001/0/0/0/0/0",
                     bus3.value, bus3.busy, bus3.done, bus3.seg, bus3.com, bus3.state);
            n_fail++;
        end
        n_tests++;
        if (bus2.value !== 8'h01 || bus2.busy !== 1'b0 || bus2.com !== 2'd0) begin
            $display("FAIL reset2 got value=%h busy=%b com=%b exp 01/0/00",
                     bus2.value, bus2.busy, bus2.com);
            n_fail++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_com3 = ((cyc - 1) % 3 == 0) ? 3'b001 : 3'b000;
            exp_seg3 = ((cyc - 1) % 3 == 0) ? 7'b0000110 : 7'b0111111;
            exp_com2 = ((cyc - 1) % 2 == 0) ? 2'b01 : 2'b00;
            n_tests++;
            if (bus3.com !== exp_com3 || bus3.seg !== exp_seg3) begin
                $display("FAIL idle_scan3 cyc=%0d got com=%b seg=%b exp com=%b seg=%b",
                         cyc, bus3.com, bus3.seg, exp_com3, exp_seg3);
                n_fail++;
            end
            n_tests++;
            if (bus2.com !== exp_com2 || bus3.busy !== 1'b0 || bus3.done !== 1'b0) begin
                $display("FAIL idle_misc cyc=%0d got com2=%b busy=%b done=%b exp com2=%b busy=0 done=0",
                         cyc, bus2.com, bus3.busy, bus3.done, exp_com2);
                n_fail++;
            end
        end
    endtask

    task automatic test_glitch();
        for (int w = 0; w < 4 && (cyc % 4) != 3; w++) @(negedge clk);
        bus3.btn = 7'b0001000;
        @(negedge clk);
        bus3.btn = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus3.busy !== 1'b0 || bus3.value !== 12'h001 || bus3.state !== 2'd0) begin
                $display("FAIL glitch cyc=%0d got busy=%b value=%h state=%0d exp 0/001/0",
                         cyc, bus3.busy, bus3.value, bus3.state);
                n_fail++;
            end
        end
    endtask

`ifndef DICE_SPINDOWN_EN
    // Each row: button index, die size, release offset from the first busy cycle.
    task automatic test_roll();
        int idx [2];
        int die [2];
        int rel [2];
        idx = '{1, 6};
        die = '{6, 100};
        rel = '{34, 98};
        for (int t = 0; t < 2; t++) begin
            int          b_cyc, d_cyc, s, msd;
            bit          seen;
            logic [11:0] exp_v;
            logic [2:0]  exp_com;
            bus3.btn = 7'(1 << idx[t]);
            b_cyc    = next_tick(cyc + 1) + 5;
            seen     = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                if (bus3.busy === 1'b1) seen = 1'b1;
            end
            n_tests++;
            if (!seen || cyc != b_cyc || bus3.value !== to_bcd(die[t])) begin
                $display("FAIL roll_start die=%0d got seen=%b cyc=%0d value=%h exp cyc=%0d value=%h",
                         die[t], seen, cyc, bus3.value, b_cyc, to_bcd(die[t]));
                n_fail++;
                bus3.btn = '0;
                repeat (60) @(negedge clk);
                continue;
            end
            d_cyc = next_tick(b_cyc + rel[t] + 1) + 4;
            while (cyc < d_cyc) begin
                @(negedge clk);
                if (cyc == b_cyc + rel[t]) bus3.btn = '0;
                exp_v = to_bcd(die[t] - ((cyc - b_cyc) % die[t]));
                n_tests++;
                if (bus3.value !== exp_v || bus3.busy !== 1'b1 || bus3.done !== 1'b0 ||
                    bus3.com !== 3'd0) begin
                    $display("FAIL roll_seq die=%0d cyc=%0d got value=%h busy=%b done=%b com=%b exp value=%h busy=1 done=0 com=000",
                             die[t], cyc, bus3.value, bus3.busy, bus3.done, bus3.com, exp_v);
                    n_fail++;
                end
            end
            exp_v = to_bcd(die[t] - ((d_cyc - b_cyc) % die[t]));
            @(negedge clk);
            n_tests++;
            if (bus3.done !== 1'b1 || bus3.busy !== 1'b0 || bus3.value !== exp_v) begin
                $display("FAIL roll_done die=%0d cyc=%0d got done=%b busy=%b value=%h exp 1/0/%h",
                         die[t], cyc, bus3.done, bus3.busy, bus3.value, exp_v);
                n_fail++;
            end
            msd = (exp_v[11:8] != 4'd0) ? 2 : (exp_v[7:4] != 4'd0) ? 1 : 0;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                s       = (cyc - 1) % 3;
                exp_com = (s <= msd) ? 3'(1 << s) : 3'b000;
                n_tests++;
                if (bus3.done !== 1'b0 || bus3.com !== exp_com || bus3.seg !== seg_of(exp_v[4*s +: 4])) begin
                    $display("FAIL roll_display die=%0d cyc=%0d got done=%b com=%b seg=%b exp done=0 com=%b seg=%b",
                             die[t], cyc, bus3.done, bus3.com, bus3.seg, exp_com, seg_of(exp_v[4*s +: 4]));
                    n_fail++;
                end
            end
        end
    endtask
`else
    task automatic test_spin();
        int  b_cyc, d1, p, d2, exp_done;
        bit  seen;
        bus3.btn = 7'b0100000;
        b_cyc    = next_tick(cyc + 1) + 5;
        seen     = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (bus3.busy === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || cyc != b_cyc || bus3.value !== 12'h020) begin
            $display("FAIL spin_start got seen=%b cyc=%0d value=%h exp cyc=%0d value=020",
                     seen, cyc, bus3.value, b_cyc);
            n_fail++;
            bus3.btn = '0;
            return;
        end
        d1 = next_tick(b_cyc + 11) + 4;
        p  = d1 + 21;
        while (cyc < p - 1) begin
            @(negedge clk);
            if (cyc == b_cyc + 10) bus3.btn = '0;
            if (cyc == d1 + 12)    bus3.btn = 7'b0000001;
            n_tests++;
            if (bus3.busy !== 1'b1 || bus3.done !== 1'b0) begin
                $display("FAIL spin_hold cyc=%0d got busy=%b done=%b exp 1/0", cyc, bus3.busy, bus3.done);
                n_fail++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus3.value !== to_bcd(4 - (k % 4)) || bus3.state !== 2'd1 || bus3.done !== 1'b0) begin
                $display("FAIL spin_repress cyc=%0d got value=%h state=%0d done=%b exp value=%h state=1 done=0",
                         cyc, bus3.value, bus3.state, bus3.done, to_bcd(4 - (k % 4)));
                n_fail++;
            end
        end
        d2       = next_tick(p + 21) + 4;
        exp_done = d2 + 124;
        while (cyc < exp_done - 1) begin
            @(negedge clk);
            if (cyc == p + 20) bus3.btn = '0;
            n_tests++;
            if (bus3.busy !== 1'b1 || bus3.done !== 1'b0) begin
                $display("FAIL spin_settle cyc=%0d got busy=%b done=%b exp 1/0", cyc, bus3.busy, bus3.done);
                n_fail++;
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus3.done !== 1'b1 || bus3.busy !== 1'b0) begin
            $display("FAIL spin_done cyc=%0d got done=%b busy=%b exp 1/0", cyc, bus3.done, bus3.busy);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if (bus3.done !== 1'b0) begin
            $display("FAIL spin_done_pulse cyc=%0d got done=%b exp 0", cyc, bus3.done);
            n_fail++;
        end
    endtask
`endif

    task automatic test_d2();
        int b_cyc;
        bit seen;
        bus2.btn = 7'b1000000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus2.busy !== 1'b0 || bus2.value !== 8'h01) begin
                $display("FAIL d2_ignore cyc=%0d got busy=%b value=%h exp 0/01", cyc, bus2.busy, bus2.value);
                n_fail++;
            end
        end
        bus2.btn = 7'b1010000;
        b_cyc    = next_tick(cyc + 1) + 5;
        seen     = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (bus2.busy === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || cyc != b_cyc || bus2.value !== 8'h12) begin
            $display("FAIL d2_press got seen=%b cyc=%0d value=%h exp cyc=%0d value=12",
                     seen, cyc, bus2.value, b_cyc);
            n_fail++;
        end
        bus2.btn = '0;
        seen     = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clk);
            if (bus2.busy === 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            $display("FAIL d2_release got busy=%b exp 0 within 400 cycles", bus2.busy);
            n_fail++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
`ifdef DICE_SPINDOWN_EN
        test_spin();
`else
        test_roll();
`endif
        test_d2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
